// File: rtl/instr_issue_ctrl_if.sv
// Host entry channel and CU run/done channel of the instruction issue controller.
// Host channel: an entry transfers on a rising clk edge where s_valid && s_ready;
// s_valid/s_instr/s_data must hold until then, and s_ready never depends on s_valid.
interface instr_issue_ctrl_if;
    logic        s_valid;
    logic        s_ready;
    logic [8:0]  s_instr;
    logic [15:0] s_data;
    logic        cu_run;
    logic [8:0]  cu_ir;
    logic [15:0] cu_din;
    logic        cu_done;

    modport master (
        output s_valid, s_instr, s_data, cu_done,
        input  s_ready, cu_run, cu_ir, cu_din
    );

    modport slave (
        input  s_valid, s_instr, s_data, cu_done,
        output s_ready, cu_run, cu_ir, cu_din
    );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Buffers host instruction/data pairs and runs the CU on them one at a time,
// with a one-cycle gap, illegal-opcode drop, run timeout and single-step gating.
module instr_issue_ctrl #(
    parameter int          DEPTH       = 4,
    parameter int          TIMEOUT     = 15,
    // Reset value of the retired counter; nonzero only for counter-wrap bring-up.
    parameter logic [15:0] RETIRED_RST = 16'h0000
) (
    input  logic                       clk,
    input  logic                       resetn,
    instr_issue_ctrl_if.slave          bus,
    input  logic                       step_en,
    input  logic                       step_go,
    input  logic                       err_clr,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [15:0]                retired,
    output logic                       illegal_err,
    output logic                       timeout_err,
    output logic [1:0]                 state_dbg
);
    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [7:0]  TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

    state_t        state;
    logic [8:0]    ir_mem  [DEPTH];
    logic [15:0]   din_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    timer;
    logic          step_tok;
    logic          push;
    logic          pop;
    logic          perm;
    logic [8:0]    head_ir;
    logic          head_legal;

    // No bypass: a full FIFO refuses the host even in a cycle that pops.
    assign bus.s_ready = (fifo_count < CW'(DEPTH));
    assign push        = bus.s_valid && bus.s_ready;
    assign perm        = !step_en || step_tok;
    assign head_ir     = ir_mem[rd_ptr];
    assign head_legal  = !head_ir[8];
    assign pop         = (state == IDLE) && (fifo_count != '0) && perm;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr]  <= bus.s_instr;
            din_mem[wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            bus.cu_run  <= 1'b0;
            bus.cu_ir   <= '0;
            bus.cu_din  <= '0;
            busy        <= 1'b0;
            timer       <= '0;
            retired     <= RETIRED_RST;
            illegal_err <= 1'b0;
            timeout_err <= 1'b0;
            step_tok    <= 1'b0;
        end else begin
            // Later assignments below win, so a set event beats err_clr.
            if (err_clr) begin
                illegal_err <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (!step_en)     step_tok <= 1'b0;
            else if (step_go) step_tok <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        step_tok <= 1'b0;
                        if (head_legal) begin
                            bus.cu_ir  <= head_ir;
                            bus.cu_din <= din_mem[rd_ptr];
                            bus.cu_run <= 1'b1;
                            busy       <= 1'b1;
                            timer      <= '0;
                            state      <= ISSUE;
                        end else begin
                            illegal_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    timer <= timer + 8'd1;
                    if (bus.cu_done) begin
                        retired    <= retired + 16'd1;
                        bus.cu_run <= 1'b0;
                        state      <= GAP;
                    end else if (timer == TMAX) begin
                        timeout_err <= 1'b1;
                        bus.cu_run  <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus.cu_run <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
